// File: rtl/block_fetch_4x4_if.sv
// Request, frame-memory and block-output bundle for block_fetch_4x4.
// Defining FETCH_TOPRIGHT_EN adds the top-right neighbour signals.
interface block_fetch_4x4_if;
  logic         req_valid;
  logic         req_ready;
  logic [31:0]  req_mbnumber;
  logic         mem_rd_en;
  logic [19:0]  mem_addr;
  logic [7:0]   mem_rd_data;
  logic         blk_valid;
  logic         blk_ready;
  logic [127:0] blk_pixels;
  logic [31:0]  blk_top;
  logic [31:0]  blk_left;
  logic [7:0]   blk_topleft;
  logic         top_avail;
  logic         left_avail;
  logic         blk_err;
`ifdef FETCH_TOPRIGHT_EN
  logic [31:0]  blk_topright;
  logic         topright_avail;

  modport master (
    output req_valid, req_mbnumber, mem_rd_data, blk_ready,
    input  req_ready, mem_rd_en, mem_addr, blk_valid, blk_pixels, blk_top,
           blk_left, blk_topleft, top_avail, left_avail, blk_err,
           blk_topright, topright_avail
  );

  modport slave (
    input  req_valid, req_mbnumber, mem_rd_data, blk_ready,
    output req_ready, mem_rd_en, mem_addr, blk_valid, blk_pixels, blk_top,
           blk_left, blk_topleft, top_avail, left_avail, blk_err,
           blk_topright, topright_avail
  );
`else
  modport master (
    output req_valid, req_mbnumber, mem_rd_data, blk_ready,
    input  req_ready, mem_rd_en, mem_addr, blk_valid, blk_pixels, blk_top,
           blk_left, blk_topleft, top_avail, left_avail, blk_err
  );

  modport slave (
    input  req_valid, req_mbnumber, mem_rd_data, blk_ready,
    output req_ready, mem_rd_en, mem_addr, blk_valid, blk_pixels, blk_top,
           blk_left, blk_topleft, top_avail, left_avail, blk_err
  );
`endif
endinterface

// File: rtl/block_fetch_4x4.sv
// Fetches a 4x4 luma block plus its top/left/topleft neighbours from frame memory.
// Defining FETCH_TOPRIGHT_EN also fetches the four top-right neighbours.
module block_fetch_4x4 #(
  parameter int FRAME_W = 1280,
  parameter int FRAME_H = 720
) (
  input  logic              clk,
  input  logic              reset,
  block_fetch_4x4_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, FETCH, DRAIN, OUT} state_t;
  typedef enum logic [2:0] {GRP_TL, GRP_TOP, GRP_LEFT, GRP_CUR, GRP_TR} grp_t;

  state_t state, state_nxt;

  logic [15:0] req_row, req_col;
  logic        accept, legal;
  logic [15:0] row, col;
  logic        top_av, left_av, err;
  logic [4:0]  idx, n_reads, rem;
  grp_t        rd_grp, pend_grp;
  logic [3:0]  rd_sub, pend_sub;
  logic        pend_valid;
  logic [19:0] row20, col20, y, x;

  logic [15:0][7:0] pix;
  logic [3:0][7:0]  top_px, left_px;
  logic [7:0]       tl_px;
`ifdef FETCH_TOPRIGHT_EN
  logic             tr_av, req_tr_ok;
  logic [3:0][7:0]  tr_px;
`endif

  assign req_row  = bus.req_mbnumber[31:16];
  assign req_col  = bus.req_mbnumber[15:0];
  assign accept   = bus.req_valid && bus.req_ready;
  assign legal    = (req_row[1:0] == 2'd0) && (req_col[1:0] == 2'd0) &&
                    ({16'd0, req_row} <= 32'(FRAME_H - 4)) &&
                    ({16'd0, req_col} <= 32'(FRAME_W - 4));
`ifdef FETCH_TOPRIGHT_EN
  assign req_tr_ok = ({16'd0, req_col} + 32'd4) <= 32'(FRAME_W - 4);
`endif

  // Read count depends only on which neighbour groups exist for this block
  always_comb begin
    n_reads = 5'd16;
    if (top_av && left_av) n_reads = n_reads + 5'd1;
    if (top_av)            n_reads = n_reads + 5'd4;
    if (left_av)           n_reads = n_reads + 5'd4;
`ifdef FETCH_TOPRIGHT_EN
    if (tr_av)             n_reads = n_reads + 5'd4;
`endif
  end

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = legal ? FETCH : OUT;
      FETCH:   if (idx == n_reads - 5'd1) state_nxt = DRAIN;
      DRAIN:   state_nxt = OUT;
      OUT:     if (bus.blk_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Peel the linear read index through the groups, skipping missing ones
  always_comb begin
    rd_grp = GRP_CUR;
    rd_sub = 4'd0;
    rem    = idx;
    if (top_av && left_av && rem == 5'd0) begin
      rd_grp = GRP_TL;
    end else begin
      if (top_av && left_av) rem = rem - 5'd1;
      if (top_av && rem < 5'd4) begin
        rd_grp = GRP_TOP;
        rd_sub = rem[3:0];
      end else begin
        if (top_av) rem = rem - 5'd4;
        if (left_av && rem < 5'd4) begin
          rd_grp = GRP_LEFT;
          rd_sub = rem[3:0];
        end else begin
          if (left_av) rem = rem - 5'd4;
`ifdef FETCH_TOPRIGHT_EN
          if (rem >= 5'd16) begin
            rd_grp = GRP_TR;
            rem    = rem - 5'd16;
          end
`endif
          rd_sub = rem[3:0];
        end
      end
    end
  end

  always_comb begin
    row20 = {4'd0, row};
    col20 = {4'd0, col};
    y     = row20;
    x     = col20;
    case (rd_grp)
      GRP_TL:   begin y = row20 - 20'd1;              x = col20 - 20'd1;              end
      GRP_TOP:  begin y = row20 - 20'd1;              x = col20 + {16'd0, rd_sub};    end
      GRP_LEFT: begin y = row20 + {16'd0, rd_sub};    x = col20 - 20'd1;              end
      GRP_CUR:  begin y = row20 + {18'd0, rd_sub[3:2]}; x = col20 + {18'd0, rd_sub[1:0]}; end
`ifdef FETCH_TOPRIGHT_EN
      GRP_TR:   begin y = row20 - 20'd1;              x = col20 + 20'd4 + {16'd0, rd_sub}; end
`endif
      default:  begin y = row20;                      x = col20;                      end
    endcase
  end

  // Reads return one cycle later, so the destination slot is pipelined with them
  always_ff @(posedge clk) begin
    if (reset) begin
      row        <= '0;
      col        <= '0;
      top_av     <= 1'b0;
      left_av    <= 1'b0;
      err        <= 1'b0;
      idx        <= '0;
      pend_valid <= 1'b0;
      pend_grp   <= GRP_TL;
      pend_sub   <= '0;
      pix        <= '0;
      top_px     <= '0;
      left_px    <= '0;
      tl_px      <= '0;
`ifdef FETCH_TOPRIGHT_EN
      tr_av      <= 1'b0;
      tr_px      <= '0;
`endif
    end else begin
      if (accept) begin
        row     <= req_row;
        col     <= req_col;
        idx     <= '0;
        err     <= !legal;
        top_av  <= legal && (req_row != 16'd0);
        left_av <= legal && (req_col != 16'd0);
        pix     <= '0;
        top_px  <= legal ? {4{8'h80}} : '0;
        left_px <= legal ? {4{8'h80}} : '0;
        tl_px   <= legal ? 8'h80 : 8'h00;
`ifdef FETCH_TOPRIGHT_EN
        tr_av   <= legal && (req_row != 16'd0) && req_tr_ok;
        tr_px   <= legal ? {4{8'h80}} : '0;
`endif
      end
      if (state == FETCH) idx <= idx + 5'd1;
      pend_valid <= (state == FETCH);
      pend_grp   <= rd_grp;
      pend_sub   <= rd_sub;
      if (pend_valid) begin
        case (pend_grp)
          GRP_TL:   tl_px <= bus.mem_rd_data;
          GRP_TOP:  top_px[pend_sub[1:0]] <= bus.mem_rd_data;
          GRP_LEFT: left_px[pend_sub[1:0]] <= bus.mem_rd_data;
          GRP_CUR:  pix[pend_sub] <= bus.mem_rd_data;
`ifdef FETCH_TOPRIGHT_EN
          GRP_TR:   tr_px[pend_sub[1:0]] <= bus.mem_rd_data;
`endif
          default:  ;
        endcase
      end
    end
  end

  assign bus.req_ready   = (state == IDLE) && !reset;
  assign bus.mem_rd_en   = (state == FETCH);
  assign bus.mem_addr    = (state == FETCH) ? (y * 20'(FRAME_W) + x) : 20'd0;
  assign bus.blk_valid   = (state == OUT);
  assign bus.blk_pixels  = pix;
  assign bus.blk_top     = top_px;
  assign bus.blk_left    = left_px;
  assign bus.blk_topleft = tl_px;
  assign bus.top_avail   = top_av;
  assign bus.left_avail  = left_av;
  assign bus.blk_err     = err;
`ifdef FETCH_TOPRIGHT_EN
  assign bus.blk_topright   = tr_px;
  assign bus.topright_avail = tr_av;
`endif

endmodule

// File: tb/tb_block_fetch_4x4.sv
// Self-checking bench for block_fetch_4x4: vector table, reset corner cases and
// randomized requests against a coordinate-level reference model.
module tb_block_fetch_4x4;

  localparam int FW = 1280;
  localparam int FH = 720;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  block_fetch_4x4_if bus ();

  block_fetch_4x4 #(.FRAME_W(FW), .FRAME_H(FH)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // Frame memory: data equals the low address byte, garbage when not read
  always @(posedge clk) bus.mem_rd_data <= bus.mem_rd_en ? bus.mem_addr[7:0] : 8'hA5;

  typedef struct {
    int row;
    int col;
    int hold;
    int n_def;
    int n_tr;
  } vec_t;

  vec_t vecs[10];
  int   checks = 0;
  int   errors = 0;

  bit           m_err, m_ta, m_la, m_tra;
  logic [127:0] m_pix;
  logic [31:0]  m_top, m_left, m_tr;
  logic [7:0]   m_tl;
  int           m_addrs[$];
  int           obs_addrs[$];
  int           obs_cycles[$];

  task automatic checkOutput(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s got %0h want %0h", name, act, exp);
    end
  endtask

  function automatic int addrOf(input int y, input int x);
    return (y * FW + x) & 32'hFFFFF;
  endfunction

  // Reference: list every pixel the block needs, in fetch order, by coordinates
  task automatic buildModel(input int row, input int col);
    int a;
    m_addrs.delete();
    m_pix = '0; m_top = '0; m_left = '0; m_tl = '0; m_tr = '0;
    m_ta = 0; m_la = 0; m_tra = 0;
    m_err = !((row % 4 == 0) && (col % 4 == 0) && (row <= FH - 4) && (col <= FW - 4));
    if (!m_err) begin
      m_ta = (row != 0);
      m_la = (col != 0);
`ifdef FETCH_TOPRIGHT_EN
      m_tra = m_ta && (col + 4 <= FW - 4);
`endif
      m_top = 32'h80808080; m_left = 32'h80808080; m_tl = 8'h80; m_tr = 32'h80808080;
      if (m_ta && m_la) begin
        a = addrOf(row - 1, col - 1); m_addrs.push_back(a); m_tl = a[7:0];
      end
      if (m_ta) for (int i = 0; i < 4; i++) begin
        a = addrOf(row - 1, col + i); m_addrs.push_back(a); m_top[8*i +: 8] = a[7:0];
      end
      if (m_la) for (int i = 0; i < 4; i++) begin
        a = addrOf(row + i, col - 1); m_addrs.push_back(a); m_left[8*i +: 8] = a[7:0];
      end
      for (int i = 0; i < 16; i++) begin
        a = addrOf(row + i / 4, col + i % 4); m_addrs.push_back(a); m_pix[8*i +: 8] = a[7:0];
      end
      if (m_tra) for (int i = 0; i < 4; i++) begin
        a = addrOf(row - 1, col + 4 + i); m_addrs.push_back(a); m_tr[8*i +: 8] = a[7:0];
      end
    end
  endtask

  function automatic logic [255:0] outSnapshot();
    logic [255:0] s = '0;
    s[127:0]   = bus.blk_pixels;
    s[159:128] = bus.blk_top;
    s[191:160] = bus.blk_left;
    s[199:192] = bus.blk_topleft;
    s[200]     = bus.blk_err;
    s[201]     = bus.top_avail;
    s[202]     = bus.left_avail;
    s[203]     = bus.blk_valid;
`ifdef FETCH_TOPRIGHT_EN
    s[235:204] = bus.blk_topright;
    s[236]     = bus.topright_avail;
`endif
    return s;
  endfunction

  // Issue one request and record reads until blk_valid (bounded)
  task automatic applyStimulus(input int row, input int col, output int valid_cycle);
    @(negedge clk);
    checkOutput("req_ready_idle", bus.req_ready, 1);
    bus.req_valid    = 1'b1;
    bus.req_mbnumber = {row[15:0], col[15:0]};
    @(posedge clk);
    #1 bus.req_valid = 1'b0;
    obs_addrs.delete();
    obs_cycles.delete();
    valid_cycle = -1;
    for (int k = 1; k <= 60; k++) begin
      @(negedge clk);
      if (bus.mem_rd_en) begin
        obs_addrs.push_back(int'(bus.mem_addr));
        obs_cycles.push_back(k);
      end
      if (bus.blk_valid) begin
        valid_cycle = k;
        break;
      end
    end
  endtask

  task automatic verifyTxn(input int valid_cycle, input int exp_n);
    int cnt;
    checkOutput("valid_cycle", valid_cycle, m_err ? 1 : exp_n + 2);
    checkOutput("read_count", obs_addrs.size(), exp_n);
    cnt = (obs_addrs.size() < m_addrs.size()) ? obs_addrs.size() : m_addrs.size();
    for (int i = 0; i < cnt; i++) checkOutput("read_addr", obs_addrs[i], m_addrs[i]);
    if (exp_n > 0 && obs_cycles.size() > 0) begin
      checkOutput("first_read_cycle", obs_cycles[0], 1);
      checkOutput("last_read_cycle", obs_cycles[obs_cycles.size()-1], exp_n);
    end
    checkOutput("blk_err", bus.blk_err, m_err);
    checkOutput("top_avail", bus.top_avail, m_ta);
    checkOutput("left_avail", bus.left_avail, m_la);
    checkOutput("blk_pixels", bus.blk_pixels, m_pix);
    checkOutput("blk_top", bus.blk_top, m_top);
    checkOutput("blk_left", bus.blk_left, m_left);
    checkOutput("blk_topleft", bus.blk_topleft, m_tl);
`ifdef FETCH_TOPRIGHT_EN
    checkOutput("topright_avail", bus.topright_avail, m_tra);
    checkOutput("blk_topright", bus.blk_topright, m_tr);
`endif
    checkOutput("req_ready_busy", bus.req_ready, 0);
  endtask

  // Back-pressure for hold cycles, then one handshake
  task automatic finishTxn(input int hold);
    logic [255:0] snap;
    snap = outSnapshot();
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      checkOutput("hold_stable", outSnapshot(), snap);
      checkOutput("hold_req_ready", bus.req_ready, 0);
    end
    bus.blk_ready = 1'b1;
    @(negedge clk);
    bus.blk_ready = 1'b0;
    checkOutput("valid_dropped", bus.blk_valid, 0);
    checkOutput("req_ready_after", bus.req_ready, 1);
  endtask

  task automatic runVector(input int row, input int col, input int hold, input int exp_n);
    int vc;
    buildModel(row, col);
    applyStimulus(row, col, vc);
    verifyTxn(vc, exp_n);
    if (row == 0 && col == 0) checkOutput("byte4_addr1280", bus.blk_pixels[39:32], 8'h00);
    if (row == 4 && col == 4) begin
      checkOutput("topleft_addr3843", bus.blk_topleft, 8'h03);
      checkOutput("top_4_4", bus.blk_top, 32'h07060504);
    end
    finishTxn(hold);
  endtask

  initial begin
    int row, col, r;
    reset            = 1'b1;
    bus.req_valid    = 1'b0;
    bus.req_mbnumber = '0;
    bus.blk_ready    = 1'b0;

    vecs[0] = '{0,    0,    0,  16, 16};
    vecs[1] = '{4,    4,    10, 25, 29};
    vecs[2] = '{0,    1278, 0,  0,  0};
    vecs[3] = '{716,  1276, 1,  25, 25};
    vecs[4] = '{0,    4,    0,  20, 20};
    vecs[5] = '{4,    0,    2,  20, 24};
    vecs[6] = '{4,    1276, 0,  25, 25};
    vecs[7] = '{4,    8,    0,  25, 29};
    vecs[8] = '{6,    4,    0,  0,  0};
    vecs[9] = '{720,  0,    0,  0,  0};

    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    checkOutput("rst_req_ready", bus.req_ready, 1);
    checkOutput("rst_blk_valid", bus.blk_valid, 0);
    checkOutput("rst_mem_rd_en", bus.mem_rd_en, 0);
    checkOutput("rst_mem_addr", bus.mem_addr, 0);
    checkOutput("rst_outputs", outSnapshot(), '0);

    $display("[TB] table vectors");
    for (int i = 0; i < 10; i++) begin
`ifdef FETCH_TOPRIGHT_EN
      runVector(vecs[i].row, vecs[i].col, vecs[i].hold, vecs[i].n_tr);
`else
      runVector(vecs[i].row, vecs[i].col, vecs[i].hold, vecs[i].n_def);
`endif
    end

    $display("[TB] reset during fetch");
    @(negedge clk);
    bus.req_valid    = 1'b1;
    bus.req_mbnumber = {16'd4, 16'd4};
    @(posedge clk);
    #1 bus.req_valid = 1'b0;
    repeat (8) @(negedge clk);
    checkOutput("midfetch_rd_en", bus.mem_rd_en, 1);
    reset = 1'b1;
    @(negedge clk);
    checkOutput("rst_rd_en_off", bus.mem_rd_en, 0);
    checkOutput("rst_no_valid", bus.blk_valid, 0);
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checkOutput("post_rst_req_ready", bus.req_ready, 1);
      checkOutput("post_rst_outputs", outSnapshot(), '0);
    end
    runVector(0, 0, 0, 16);

    $display("[TB] random requests");
    for (int i = 0; i < 24; i++) begin
      r = $urandom_range(0, 99);
      if (r < 20) begin
        row = $urandom_range(0, 800);
        col = $urandom_range(0, 1400);
      end else begin
        row = 4 * $urandom_range(0, 179);
        col = 4 * $urandom_range(0, 319);
      end
      buildModel(row, col);
      runVector(row, col, $urandom_range(0, 3), m_addrs.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/block_fetch_4x4.md
BLOCK_FETCH_4X4 -- requirements
Module: block_fetch_4x4

Interface
REQ-001 SHALL have parameter FRAME_W, default 1280, luma frame width in pixels.
REQ-002 SHALL have parameter FRAME_H, default 720, luma frame height in pixels.
REQ-003 SHALL have port clk, input, 1, single clock; all logic on its rising edge.
REQ-004 SHALL have port reset, input, 1, synchronous active-high reset.
REQ-005 SHALL have ports req_valid (input, 1) and req_ready (output, 1), the block-request handshake.
REQ-006 SHALL have port req_mbnumber, input, 32, the request position: {row[31:16], col[15:0]} in pixels.
REQ-007 SHALL have ports mem_rd_en (output, 1), mem_addr (output, 20) and mem_rd_data (input, 8), the frame-memory read port; read latency is 1 cycle.
REQ-008 SHALL have ports blk_valid (output, 1) and blk_ready (input, 1), the output handshake.
REQ-009 SHALL have port blk_pixels, output, 128, 16 pixels in raster order, pixel 0 in [7:0].
REQ-010 SHALL have ports blk_top (output, 32), blk_left (output, 32) and blk_topleft (output, 8), the neighbour pixels; index 0 is in the low byte.
REQ-011 SHALL have ports top_avail, left_avail and blk_err, each output, 1.

Function
REQ-012 SHALL hold req_ready=1 only in IDLE; a request is accepted on a cycle where req_valid and req_ready are both 1, and req_mbnumber is latched on that cycle.
REQ-013 SHALL treat a request as illegal when row>FRAME_H-4, or col>FRAME_W-4, or row[1:0]!=0, or col[1:0]!=0.
REQ-014 SHALL, for an illegal request, issue no reads, assert blk_valid the cycle after acceptance with blk_err=1, and drive all pixel and neighbour outputs to 0.
REQ-015 SHALL set top_avail=(row!=0) and left_avail=(col!=0); topleft is read only when both are 1.
REQ-016 SHALL compute the read address as y*FRAME_W+x, truncated to 20 bits.
REQ-017 SHALL issue reads in this order, skipping unavailable groups:
  - topleft (row-1, col-1);
  - top 4 (row-1, col..col+3);
  - left 4 (row..row+3, col-1);
  - current 16 (raster order).
REQ-018 SHALL issue one read per cycle with no bubbles; with N reads, the first mem_rd_en is in cycle 1 after acceptance, the last in cycle N, and blk_valid rises in cycle N+2.
REQ-019 SHALL drive unavailable neighbour bytes to 8'h80.
REQ-020 SHALL use states IDLE -> FETCH -> DRAIN -> OUT -> IDLE:
  - FETCH runs until the last read is issued;
  - DRAIN captures the final data;
  - OUT holds until blk_ready.
REQ-021 SHALL hold all blk_* outputs stable while blk_valid=1 and blk_ready=0.
REQ-022 SHALL drop blk_valid the cycle after the output handshake, then accept a new request from IDLE (req_ready=1 that cycle).
REQ-023 SHALL keep mem_rd_en=0 outside FETCH.

Reset
REQ-024 SHALL, with reset=1, return to IDLE on that clock edge, from any state including mid-FETCH.
REQ-025 SHALL reset outputs to: req_ready=1 from the first cycle after reset deasserts; blk_valid=0, mem_rd_en=0, mem_addr=0, blk_err=0, avail flags=0, data outputs=0.
REQ-026 SHALL ignore mem_rd_data that returns after a reset.

Configuration
REQ-027 SHALL, when macro FETCH_TOPRIGHT_EN is defined:
  - add outputs blk_topright (32) and topright_avail (1);
  - set topright_avail=top_avail && (col+4<=FRAME_W-4);
  - read top-right 4 (row-1, col+4..col+7) last, when available;
  - drive blk_topright to 8'h80 when unavailable.
REQ-028 SHALL, when FETCH_TOPRIGHT_EN is undefined, omit those ports and reads, leaving N unchanged.

Verification (memory model: data = addr[7:0])
REQ-029 SHALL cover request {0,0}: N=16, top_avail=0, left_avail=0, neighbours=0x80, blk_pixels byte4=addr 1280 (0x00), blk_valid at cycle 18.
REQ-030 SHALL cover request {4,4}: N=25, blk_topleft=addr 3843 (0x03), blk_top=0x07060504, blk_valid at cycle 27.
REQ-031 SHALL cover blk_ready low for 10 cycles after blk_valid: outputs stable, req_ready=0, then one handshake and req_ready=1 the next cycle.
REQ-032 SHALL cover illegal request {0,1278}: no mem_rd_en, blk_valid with blk_err=1 at cycle 1.
REQ-033 SHALL cover reset at cycle 8 of a fetch of {4,4}: no blk_valid, mem_rd_en=0 next cycle, req_ready=1 the cycle after reset deasserts.
REQ-034 SHALL cover, with FETCH_TOPRIGHT_EN: {4,1276} gives topright_avail=0 and N=25; {4,8} gives N=29 and blk_valid at cycle 31.
